// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline encodings: ALU controls, mul/div ops, sequencer states
package pipe_pkg;

    // ALU control encodings shared by alu, decoder and mul_div_sequencer
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // mul_div_sequencer operation select
    localparam logic OP_MUL  = 1'b0;
    localparam logic OP_DIVU = 1'b1;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_MUL  = 2'd1,
        MDS_DIV  = 2'd2,
        MDS_DONE = 2'd3
    } mds_state_t;

endpackage

// File: rtl/mul_div_sequencer.sv
// rtl/mul_div_sequencer.sv - iterative unsigned MUL/DIVU sequencer borrowing the shared ALU
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   Start, Op             request pulse (taken only in IDLE), 0 = MUL, 1 = DIVU
//   OperandA, OperandB    multiplicand/dividend, multiplier/divisor
//   AluOwn                high while this block drives the shared ALU
//   ALUControl, SrcA/SrcB ALU control and operands (0 when not owning)
//   ALUResult             combinational result from the shared ALU
//   Busy, Stall           high in MUL, DIV and DONE
//   Done                  one-cycle pulse in DONE
//   Result, Remainder     product/quotient and remainder, held until next accepted Start
module mul_div_sequencer
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    output logic             AluOwn,
    output logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] SrcA,
    output logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] ALUResult,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Remainder
);

    mds_state_t state, state_nxt;

    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] rem, quo, dvsr;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   rs;
    logic             ge;
    logic             last;
    logic             div_by_zero;

    // Partial remainder shifted left with the next dividend bit; it can reach
    // 33 bits, so the compare is done locally rather than through the ALU.
    assign rs          = {rem, quo[WIDTH-1]};
    assign ge          = rs >= {1'b0, dvsr};
    assign last        = (cnt == {CNT_W{1'b1}});
    assign div_by_zero = (Op == OP_DIVU) && (OperandB == '0);

    assign Busy  = (state != MDS_IDLE);
    assign Stall = Busy;
    assign Done  = (state == MDS_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MDS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        AluOwn     = 1'b0;
        ALUControl = ALU_ADD;
        SrcA       = '0;
        SrcB       = '0;
        case (state)
            MDS_IDLE: begin
                if (Start) begin
                    if (Op == OP_MUL) begin
                        state_nxt = MDS_MUL;
                    end else if (div_by_zero) begin
                        state_nxt = MDS_DONE;
                    end else begin
                        state_nxt = MDS_DIV;
                    end
                end
            end
            MDS_MUL: begin
                AluOwn     = 1'b1;
                ALUControl = ALU_ADD;
                SrcA       = acc;
                SrcB       = mplier[0] ? mcand : '0;
                if (last) begin
                    state_nxt = MDS_DONE;
                end
            end
            MDS_DIV: begin
                // Difference is only kept when ge, in which case it fits in 32 bits.
                AluOwn     = 1'b1;
                ALUControl = ALU_SUB;
                SrcA       = rs[WIDTH-1:0];
                SrcB       = dvsr;
                if (last) begin
                    state_nxt = MDS_DONE;
                end
            end
            MDS_DONE: begin
                state_nxt = MDS_IDLE;
            end
            default: begin
                state_nxt = MDS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            cnt       <= '0;
            Result    <= '0;
            Remainder <= '0;
        end else begin
            case (state)
                MDS_IDLE: begin
                    if (Start) begin
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= OperandA;
                        mplier <= OperandB;
                        rem    <= '0;
                        quo    <= OperandA;
                        dvsr   <= OperandB;
                        if (div_by_zero) begin
                            Result    <= '1;
                            Remainder <= OperandA;
                        end else begin
                            Result    <= '0;
                            Remainder <= '0;
                        end
                    end
                end
                MDS_MUL: begin
                    acc    <= ALUResult;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        Result    <= ALUResult;
                        Remainder <= '0;
                    end
                end
                MDS_DIV: begin
                    rem <= ge ? ALUResult : rs[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        Result    <= {quo[WIDTH-2:0], ge};
                        Remainder <= ge ? ALUResult : rs[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb/tb_mul_div_sequencer.sv - self-checking bench for mul_div_sequencer with behavioural model
module tb_mul_div_sequencer;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic        Op = 1'b0;
    logic [31:0] OperandA = '0;
    logic [31:0] OperandB = '0;
    logic        AluOwn;
    logic [2:0]  ALUControl;
    logic [31:0] SrcA, SrcB, ALUResult;
    logic        Busy, Stall, Done;
    logic [31:0] Result, Remainder;

    int checks = 0;
    int errors = 0;

    mul_div_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB),
        .AluOwn(AluOwn), .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
        .ALUResult(ALUResult), .Busy(Busy), .Stall(Stall), .Done(Done),
        .Result(Result), .Remainder(Remainder)
    );

    always #5 clk = ~clk;

    // Shared ALU stand-in
    assign ALUResult = (ALUControl == ALU_SUB) ? SrcA - SrcB : SrcA + SrcB;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: cycles left in the busy window and the architectural results.
    int          m_left = 0;
    logic        m_op = 1'b0;
    logic [31:0] m_res = '0, m_rem = '0, p_res = '0, p_rem = '0;
    logic [63:0] prod;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0;
            m_res  = '0;
            m_rem  = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 1) begin
                m_res = p_res;
                m_rem = p_rem;
            end
        end else if (Start) begin
            m_op = Op;
            if (Op && OperandB == 0) begin
                m_left = 1;
                m_res  = 32'hFFFF_FFFF;
                m_rem  = OperandA;
            end else begin
                m_left = 33;
                m_res  = '0;
                m_rem  = '0;
                if (Op) begin
                    p_res = OperandA / OperandB;
                    p_rem = OperandA % OperandB;
                end else begin
                    prod  = {32'd0, OperandA} * {32'd0, OperandB};
                    p_res = prod[31:0];
                    p_rem = '0;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic own;
        own = (m_left > 1);
        chk("busy", {31'd0, Busy}, {31'd0, m_left > 0});
        chk("stall", {31'd0, Stall}, {31'd0, m_left > 0});
        chk("done", {31'd0, Done}, {31'd0, m_left == 1});
        chk("aluown", {31'd0, AluOwn}, {31'd0, own});
        chk("result", Result, m_res);
        chk("remainder", Remainder, m_rem);
        if (own) begin
            chk("alucontrol", {29'd0, ALUControl}, {29'd0, m_op ? ALU_SUB : ALU_ADD});
        end else begin
            chk("alucontrol_idle", {29'd0, ALUControl}, 32'd0);
            chk("srca_idle", SrcA, 32'd0);
            chk("srcb_idle", SrcB, 32'd0);
        end
    end

    // Issue an operation from an IDLE cycle (called at posedge+1), wait for Done.
    // inj_cyc > 0 pulses a conflicting Start at that busy cycle.
    task automatic run(input string name, input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eres, input logic [31:0] erem, input int elat,
                       input int estall, input logic eown, input int inj_cyc);
        int cyc;
        int stall_n;
        logic own_seen;
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        @(posedge clk); #1;
        Start = 1'b0;
        cyc = 1; stall_n = 0; own_seen = 1'b0;
        while (!Done && cyc < 100) begin
            if (AluOwn) own_seen = 1'b1;
            if (Stall) stall_n++;
            if (cyc == inj_cyc) begin
                Start = 1'b1; Op = ~op; OperandA = 32'd99; OperandB = 32'd3;
            end else begin
                Start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        Start = 1'b0;
        if (Stall) stall_n++;
        chk({name, "_latency"}, cyc, elat);
        chk({name, "_stall_cycles"}, stall_n, estall);
        chk({name, "_own_seen"}, {31'd0, own_seen}, {31'd0, eown});
        chk({name, "_result"}, Result, eres);
        chk({name, "_remainder"}, Remainder, erem);
        @(posedge clk); #1;
        chk({name, "_idle_after"}, {31'd0, Busy}, 32'd0);
        chk({name, "_result_held"}, Result, eres);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_result", Result, 32'd0);
        chk("reset_aluown", {31'd0, AluOwn}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run("mul7x6", OP_MUL, 32'd7, 32'd6, 32'd42, 32'd0, 33, 33, 1'b1, 0);
        run("mul_ff", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 33, 33, 1'b1, 0);
        run("mul_2p32", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 33, 33, 1'b1, 0);
        run("div100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33, 33, 1'b1, 0);
        run("div_rs33", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 33, 33, 1'b1, 0);
        run("div0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 1, 1'b0, 0);
        run("mul_ign", OP_MUL, 32'd3, 32'd5, 32'd15, 32'd0, 33, 33, 1'b1, 10);

        // Asynchronous reset in the middle of a divide
        Start = 1'b1; Op = OP_DIVU; OperandA = 32'd1000; OperandB = 32'd3;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_busy", {31'd0, Busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", {31'd0, Busy}, 32'd0);
        chk("async_aluown", {31'd0, AluOwn}, 32'd0);
        chk("async_srca", SrcA, 32'd0);
        chk("async_result", Result, 32'd0);
        chk("async_remainder", Remainder, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run("div_after_rst", OP_DIVU, 32'd1000, 32'd3, 32'd333, 32'd1, 33, 33, 1'b1, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
